// File: rtl/mux_2_1_if.sv
// Valid/ready bus for mux_2_1: two data sources plus select in, one registered word out.
// MUX_2_1_PARITY_EN adds the registered out_parity signal.
interface mux_2_1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mux_out;
    logic             out_valid;
    logic             out_ready;
    logic             sel_switch;
`ifdef MUX_2_1_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_0, in_1, sel, in_valid, out_ready,
        input  in_ready, mux_out, out_valid, sel_switch
`ifdef MUX_2_1_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_0, in_1, sel, in_valid, out_ready,
        output in_ready, mux_out, out_valid, sel_switch
`ifdef MUX_2_1_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/mux_2_1.sv
// Registered 2:1 mux with a single-entry valid/ready output stage and select-change flag.
// Optional even-parity output enabled by defining MUX_2_1_PARITY_EN.
module mux_2_1 #(
    parameter int WIDTH     = 1,
    parameter bit RESET_SEL = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_2_1_if.slave bus
);

    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outValid_q, outValid_d;
    logic             selSwitch_q, selSwitch_d;
    logic             prevSel_q, prevSel_d;
    logic [WIDTH-1:0] selData;
    logic             inReady;
    logic             accept;
    logic             consume;
`ifdef MUX_2_1_PARITY_EN
    logic             outParity_q, outParity_d;
`endif

    // A free slot exists when the stage is empty or its word leaves this cycle.
    assign inReady = !outValid_q || bus.out_ready;
    assign accept  = bus.in_valid && inReady;
    assign consume = outValid_q && bus.out_ready;
    assign selData = bus.sel ? bus.in_1 : bus.in_0;

    always_comb begin
        outData_d   = outData_q;
        outValid_d  = outValid_q;
        selSwitch_d = selSwitch_q;
        prevSel_d   = prevSel_q;
`ifdef MUX_2_1_PARITY_EN
        outParity_d = outParity_q;
`endif
        if (accept) begin
            outData_d   = selData;
            outValid_d  = 1'b1;
            selSwitch_d = (bus.sel != prevSel_q);
            prevSel_d   = bus.sel;
`ifdef MUX_2_1_PARITY_EN
            outParity_d = ^selData;
`endif
        end else if (consume) begin
            outValid_d  = 1'b0;
            selSwitch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            selSwitch_q <= 1'b0;
            prevSel_q   <= RESET_SEL;
`ifdef MUX_2_1_PARITY_EN
            outParity_q <= 1'b0;
`endif
        end else begin
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            selSwitch_q <= selSwitch_d;
            prevSel_q   <= prevSel_d;
`ifdef MUX_2_1_PARITY_EN
            outParity_q <= outParity_d;
`endif
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.mux_out    = outData_q;
    assign bus.out_valid  = outValid_q;
    assign bus.sel_switch = selSwitch_q;
`ifdef MUX_2_1_PARITY_EN
    assign bus.out_parity = outParity_q;
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// Scoreboard bench for mux_2_1: a WIDTH=1 and a WIDTH=8 instance driven with directed vectors.
// Define MUX_2_1_PARITY_EN to also check out_parity.
module tb_mux_2_1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_2_1_if #(.WIDTH(1)) b1 ();
    mux_2_1_if #(.WIDTH(8)) b8 ();

    mux_2_1 #(.WIDTH(1), .RESET_SEL(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux_2_1 #(.WIDTH(8), .RESET_SEL(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct packed {
        logic [7:0] data;
        logic       sw;
        logic       par;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t e1;
    exp_t e8;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one transfer, wait (bounded) for in_ready, and queue its hand-computed result.
    task automatic applyStimulus(input int which, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic s, input logic oRdy, input logic doPush,
                                 input logic [7:0] expData, input logic expSw, input logic expPar);
        logic rdy;
        rdy = 1'b0;
        @(negedge clk);
        if (which == 1) begin
            b1.in_0 = d0[0]; b1.in_1 = d1[0]; b1.sel = s; b1.in_valid = 1'b1; b1.out_ready = oRdy;
        end else begin
            b8.in_0 = d0; b8.in_1 = d1; b8.sel = s; b8.in_valid = 1'b1; b8.out_ready = oRdy;
        end
        for (int i = 0; i < 16 && !rdy; i++) begin
            #1;
            rdy = (which == 1) ? b1.in_ready : b8.in_ready;
            if (!rdy) @(negedge clk);
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        end else begin
            @(posedge clk);
            if (doPush) begin
                if (which == 1) q1.push_back('{expData, expSw, expPar});
                else            q8.push_back('{expData, expSw, expPar});
            end
        end
    endtask

    task automatic idleCycles(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (which == 1) begin b1.in_valid = 1'b0; b1.out_ready = 1'b1; end
            else            begin b8.in_valid = 1'b0; b8.out_ready = 1'b1; end
        end
    endtask

    // Monitor for the 1-bit instance: compare each consumed word against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dut1_unexpected_word: got %0h, expected no word", b1.mux_out);
                end else begin
                    e1 = q1.pop_front();
                    checkOutput("dut1_data", {7'b0, b1.mux_out}, {7'b0, e1.data[0]});
                    checkOutput("dut1_sel_switch", {7'b0, b1.sel_switch}, {7'b0, e1.sw});
`ifdef MUX_2_1_PARITY_EN
                    checkOutput("dut1_parity", {7'b0, b1.out_parity}, {7'b0, e1.par});
`endif
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dut8_unexpected_word: got %0h, expected no word", b8.mux_out);
                end else begin
                    e8 = q8.pop_front();
                    checkOutput("dut8_data", b8.mux_out, e8.data);
                    checkOutput("dut8_sel_switch", {7'b0, b8.sel_switch}, {7'b0, e8.sw});
`ifdef MUX_2_1_PARITY_EN
                    checkOutput("dut8_parity", {7'b0, b8.out_parity}, {7'b0, e8.par});
`endif
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b1.in_0 = '0; b1.in_1 = '0; b1.sel = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        b8.in_0 = '0; b8.in_1 = '0; b8.sel = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        #12;
        checkOutput("reset_mux_out", {7'b0, b1.mux_out}, 8'h00);
        checkOutput("reset_out_valid", {7'b0, b1.out_valid}, 8'h00);
        checkOutput("reset_sel_switch", {7'b0, b1.sel_switch}, 8'h00);
        checkOutput("reset_in_ready", {7'b0, b1.in_ready}, 8'h01);
        checkOutput("reset_dut8_out_valid", {7'b0, b8.out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-bit select tests: d0, d1, sel, out_ready, push, expected data, switch, parity
        applyStimulus(1, 8'h0, 8'h1, 1'b0, 1'b1, 1'b1, 8'h0, 1'b0, 1'b0);
        applyStimulus(1, 8'h1, 8'h0, 1'b1, 1'b1, 1'b1, 8'h0, 1'b1, 1'b0);
        applyStimulus(1, 8'h0, 8'h1, 1'b1, 1'b1, 1'b1, 8'h1, 1'b0, 1'b1);
        applyStimulus(1, 8'h1, 8'h0, 1'b0, 1'b1, 1'b1, 8'h1, 1'b1, 1'b1);
        idleCycles(1, 3);

        // A word stuck under backpressure is wiped by a mid-cycle reset.
        applyStimulus(1, 8'h0, 8'h1, 1'b1, 1'b0, 1'b0, 8'h1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_mux_out", {7'b0, b1.mux_out}, 8'h00);
        checkOutput("midreset_out_valid", {7'b0, b1.out_valid}, 8'h00);
        checkOutput("midreset_sel_switch", {7'b0, b1.sel_switch}, 8'h00);
        checkOutput("midreset_in_ready", {7'b0, b1.in_ready}, 8'h01);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b1.in_valid = 1'b0;
        b1.out_ready = 1'b1;
        applyStimulus(1, 8'h0, 8'h1, 1'b1, 1'b1, 1'b1, 8'h1, 1'b1, 1'b1);
        idleCycles(1, 3);

        // 8-bit backpressure: A5 held for three cycles while inputs wander.
        applyStimulus(8, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b8.in_0 = 8'h10 + 8'(i);
            b8.in_1 = 8'hF0 - 8'(i);
            b8.sel = i[0];
            b8.in_valid = 1'b1;
            #1;
            checkOutput("stall_in_ready", {7'b0, b8.in_ready}, 8'h00);
            checkOutput("stall_mux_out", b8.mux_out, 8'hA5);
            checkOutput("stall_out_valid", {7'b0, b8.out_valid}, 8'h01);
            checkOutput("stall_sel_switch", {7'b0, b8.sel_switch}, 8'h00);
`ifdef MUX_2_1_PARITY_EN
            checkOutput("stall_parity", {7'b0, b8.out_parity}, 8'h00);
`endif
        end
        applyStimulus(8, 8'h3C, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Full-throughput streaming with toggling select.
        applyStimulus(8, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(8, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        applyStimulus(8, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        applyStimulus(8, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);

        // Parity vectors.
        applyStimulus(8, 8'h00, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
        applyStimulus(8, 8'h03, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
        idleCycles(8, 4);
        #2;
        checkOutput("drain_out_valid", {7'b0, b8.out_valid}, 8'h00);
        checkOutput("drain_sel_switch", {7'b0, b8.sel_switch}, 8'h00);
        checkOutput("drain_mux_out_hold", b8.mux_out, 8'h03);
        checkOutput("drain_in_ready", {7'b0, b8.in_ready}, 8'h01);
        checkOutput("drain_q1_empty", 8'(q1.size()), 8'h00);
        checkOutput("drain_q8_empty", 8'(q8.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
